// File: rtl/case_3_sdiv_pkg.sv
// Shared types and default geometry for the sequential signed divider.
package case_3_sdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    localparam int DIN0_WIDTH = 26;
    localparam int DIN1_WIDTH = 14;
    localparam int DOUT_WIDTH = 26;

    // Counter must hold din0_WIDTH-1 (the first iteration index).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_WIDTH = cnt_width(DIN0_WIDTH);

endpackage

// File: rtl/case_3_sdiv_step.sv
// One restoring division step on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, trial-subtract the divisor,
// keep the difference when it does not borrow.
module case_3_sdiv_step #(
    parameter int DW = 14
) (
    input  logic [DW:0] rem_in,
    input  logic        bit_in,
    input  logic [DW:0] divisor,
    output logic [DW:0] rem_out,
    output logic        q_bit
);

    logic [DW+1:0] shifted;
    logic [DW+1:0] diff;

    // Trial subtraction; the extra top bit of diff is the borrow.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[DW+1];
        rem_out = q_bit ? diff[DW:0] : shifted[DW:0];
    end

endmodule

// File: rtl/case_3_sdiv_26s_14s_26_seq_1.sv
// Sequential signed divider: 26-bit dividend / 14-bit divisor, one
// restoring step per cycle, quotient truncated toward zero, remainder
// carrying the dividend's sign.
module case_3_sdiv_26s_14s_26_seq_1
    import case_3_sdiv_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIN0_WIDTH,
    parameter int din1_WIDTH = DIN1_WIDTH,
    parameter int dout_WIDTH = DOUT_WIDTH
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  dz
);

    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int CW = cnt_width(din0_WIDTH);

    if (dout_WIDTH != din0_WIDTH) begin : g_width_check
        $error("instance %0d: dout_WIDTH must equal din0_WIDTH", ID);
    end

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [W0-1:0] q_reg;
    logic [W1:0]   r_reg;
    logic [W1:0]   d_mag;
    logic          neg_q;
    logic          neg_r;

    logic [W0:0]   a_ext;
    logic [W0:0]   a_mag;
    logic [W1:0]   b_ext;
    logic [W1:0]   b_mag;
    logic [W1:0]   step_rem;
    logic          step_q;

    // Operand magnitudes, one bit wider so -2^(W-1) is exact.
    always_comb begin
        a_ext = {din0[W0-1], din0};
        a_mag = din0[W0-1] ? -a_ext : a_ext;
        b_ext = {din1[W1-1], din1};
        b_mag = din1[W1-1] ? -b_ext : b_ext;
    end

    case_3_sdiv_step #(
        .DW (W1)
    ) u_step (
        .rem_in  (r_reg),
        .bit_in  (q_reg[W0-1]),
        .divisor (d_mag),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // State register; ce low freezes the FSM.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else if (ce) begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (cnt == '0) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt   <= '0;
            q_reg <= '0;
            r_reg <= '0;
            d_mag <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            done  <= 1'b0;
            dout  <= '0;
            rem   <= '0;
            dz    <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // The magnitude's top bit is zero for every input
                        // (|-2^(W0-1)| fits W0 unsigned bits), so it simply
                        // seeds the partial remainder.
                        q_reg <= a_mag[W0-1:0];
                        r_reg <= {{W1{1'b0}}, a_mag[W0]};
                        d_mag <= b_mag;
                        neg_q <= din0[W0-1] ^ din1[W1-1];
                        neg_r <= din0[W0-1];
                        cnt   <= CW'(W0 - 1);
                    end
                end
                CALC: begin
                    q_reg <= {q_reg[W0-2:0], step_q};
                    r_reg <= step_rem;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIN: begin
                    done <= 1'b1;
                    if (d_mag == '0) begin
                        dout <= '1;
                        rem  <= '0;
                        dz   <= 1'b1;
                    end else begin
                        dout <= neg_q ? -q_reg : q_reg;
                        rem  <= neg_r ? -r_reg[W1-1:0] : r_reg[W1-1:0];
                        dz   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_case_3_sdiv_26s_14s_26_seq_1.sv
// Directed bench for the sequential signed divider: a scoreboard of
// expected results and completion cycles, checked every cycle.
module tb_case_3_sdiv_26s_14s_26_seq_1;

    typedef struct {
        logic [25:0] dout;
        logic [13:0] rem;
        logic        dz;
    } res_t;

    typedef struct {
        logic [25:0] dout;
        logic [13:0] rem;
        logic        dz;
        int          acc;
        int          done_at;
    } exp_t;

    typedef struct {
        logic signed [25:0] a;
        logic signed [13:0] b;
        logic [25:0]        ed;
        logic [13:0]        er;
        logic               edz;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        start;
    logic [25:0] din0;
    logic [13:0] din1;
    logic        busy;
    logic        done;
    logic [25:0] dout;
    logic [13:0] rem;
    logic        dz;

    int   cyc;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];
    logic [25:0] hd;
    logic [13:0] hr;
    logic        hz;

    case_3_sdiv_26s_14s_26_seq_1 #(
        .ID         (1),
        .din0_WIDTH (26),
        .din1_WIDTH (14),
        .dout_WIDTH (26)
    ) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .ce       (ce),
        .start    (start),
        .din0     (din0),
        .din1     (din1),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .rem      (rem),
        .dz       (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: signed division in plain integer arithmetic.
    function automatic res_t model(input longint a, input longint b);
        res_t   r;
        longint qq;
        longint rr;
        if (b == 0) begin
            r.dout = '1;
            r.rem  = '0;
            r.dz   = 1'b1;
        end else begin
            qq     = a / b;
            rr     = a % b;
            r.dout = qq[25:0];
            r.rem  = rr[13:0];
            r.dz   = 1'b0;
        end
        return r;
    endfunction

    task automatic start_op(input logic signed [25:0] a, input logic signed [13:0] b,
                            input res_t e, input int stall, output int acc);
        din0  = a;
        din1  = b;
        start = 1'b1;
        acc   = cyc + 1;
        sb.push_back('{e.dout, e.rem, e.dz, acc, acc + 27 + stall});
        @(posedge clk);
        #1;
        start = 1'b0;
        din0  = 26'($urandom);
        din1  = 14'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Per-cycle compare against the scoreboard and the held result.
    always @(negedge clk) begin
        logic exp_done;
        logic exp_busy;
        exp_t h;
        exp_done = (sb.size() > 0) && (sb[0].done_at == cyc);
        chk("done", 64'(done), 64'(exp_done));
        if (exp_done) begin
            h  = sb.pop_front();
            hd = h.dout;
            hr = h.rem;
            hz = h.dz;
        end
        exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].done_at);
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("dout", 64'(dout), 64'(hd));
        chk("rem", 64'(rem), 64'(hr));
        chk("dz", 64'(dz), 64'(hz));
    end

    vec_t dv[7];
    logic signed [25:0] ma[6];
    logic signed [13:0] mb[6];

    initial begin
        res_t e;
        int   acc;
        int   acc2;

        cyc    = 0;
        n_chk  = 0;
        n_fail = 0;
        hd     = '0;
        hr     = '0;
        hz     = 1'b0;
        rst_n  = 1'b0;
        ce     = 1'b1;
        start  = 1'b0;
        din0   = '0;
        din1   = '0;

        dv[0] = '{26'sd100,   14'sd7,  26'd14,        14'd2,    1'b0};
        dv[1] = '{-26'sd100,  14'sd7,  26'h3FFFFF2,   14'h3FFE, 1'b0};
        dv[2] = '{26'sd100,   -14'sd7, 26'h3FFFFF2,   14'd2,    1'b0};
        dv[3] = '{-26'sd100,  -14'sd7, 26'd14,        14'h3FFE, 1'b0};
        dv[4] = '{26'h2000000, -14'sd1, 26'h2000000,  14'd0,    1'b0};
        dv[5] = '{26'h2000000, 14'sd8191, 26'h3FFF000, 14'h3000, 1'b0};
        dv[6] = '{26'sd12345, 14'sd0,  26'h3FFFFFF,   14'd0,    1'b1};

        ma = '{26'sd33554431, 26'sd0, 26'sd7, -26'sd1, -26'sd5000000, 26'sd2048};
        mb = '{14'h2000, 14'sd5, 14'sd100, 14'sd1, 14'sd8191, 14'h2000};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pin the model against hand-computed results.
        foreach (dv[i]) begin
            e = model(longint'(dv[i].a), longint'(dv[i].b));
            chk($sformatf("model_dout_%0d", i), 64'(e.dout), 64'(dv[i].ed));
            chk($sformatf("model_rem_%0d", i), 64'(e.rem), 64'(dv[i].er));
            chk($sformatf("model_dz_%0d", i), 64'(e.dz), 64'(dv[i].edz));
        end

        // Directed vectors, expectations taken from the hand-computed table.
        foreach (dv[i]) begin
            e = '{dv[i].ed, dv[i].er, dv[i].edz};
            start_op(dv[i].a, dv[i].b, e, 0, acc);
            wait_idle();
        end

        // Further vectors checked against the model.
        foreach (ma[i]) begin
            start_op(ma[i], mb[i], model(longint'(ma[i]), longint'(mb[i])), 0, acc);
            wait_idle();
        end

        // Back-to-back: a start in the cycle right after done.
        start_op(26'sd999999, 14'sd123, model(64'sd999999, 64'sd123), 0, acc);
        wait_cyc(acc + 27);
        start_op(-26'sd424242, 14'sd77, model(-64'sd424242, 64'sd77), 0, acc2);
        wait_idle();

        // Start while busy is ignored; ce low for 3 cycles stretches latency.
        start_op(26'sd1000000, -14'sd37, model(64'sd1000000, -64'sd37), 3, acc);
        wait_cyc(acc + 4);
        din0  = 26'sd5;
        din1  = 14'sd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cyc(acc + 10);
        ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ce = 1'b1;
        wait_idle();

        // Reset mid-division clears everything at once and yields no done.
        start_op(26'sd31337, 14'sd11, model(64'sd31337, 64'sd11), 0, acc);
        wait_cyc(acc + 9);
        rst_n = 1'b0;
        sb.delete();
        hd = '0;
        hr = '0;
        hz = 1'b0;
        #1;
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_rem", 64'(rem), 64'd0);
        chk("rst_dz", 64'(dz), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_op(-26'sd77777, -14'sd300, model(-64'sd77777, -64'sd300), 0, acc);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/case_3_sdiv_26s_14s_26_seq_1.md
CASE_3_SDIV_26S_14S_26_SEQ_1 -- requirements
Module: case_3_sdiv_26s_14s_26_seq_1

Interface
REQ-001 Parameter ID, default 1, instance identifier; no functional effect.
REQ-002 Parameter din0_WIDTH, default 26, dividend width, signed two's complement.
REQ-003 Parameter din1_WIDTH, default 14, divisor width, signed two's complement.
REQ-004 Parameter dout_WIDTH, default 26, quotient width; SHALL equal din0_WIDTH.
REQ-005 One clock; reset is asynchronous and active-low: ap_clk input 1, rising-edge clock; ap_rst_n input 1, asynchronous active-low reset.
REQ-006 ce  input  1  clock enable; low freezes all state and outputs.
REQ-007 start  input  1  request; sampled only in IDLE with ce=1.
REQ-008 din0  input  din0_WIDTH  dividend, captured on accepted start.
REQ-009 din1  input  din1_WIDTH  divisor, captured on accepted start.
REQ-010 busy  output  1  high in CALC and FIN.
REQ-011 done  output  1  one-cycle pulse when results become valid.
REQ-012 dout  output  dout_WIDTH  signed quotient, held until next done.
REQ-013 rem  output  din1_WIDTH  signed remainder, held until next done.
REQ-014 dz  output  1  divide-by-zero flag for the held result.

Function
REQ-015 FSM states IDLE, CALC, FIN; every transition requires ce=1.
REQ-016 IDLE -> CALC on start=1; operand magnitudes, sign of dividend and sign of quotient (XOR) are registered; iteration counter loads din0_WIDTH-1.
REQ-017 CALC performs one restoring shift-subtract step per cycle on unsigned magnitudes, partial remainder din1_WIDTH+1 bits; counter decrements; CALC -> FIN after step with counter 0.
REQ-018 FIN applies signs, registers dout/rem/dz, asserts done for exactly one cycle, returns to IDLE.
REQ-019 Latency: with ce held high, done asserts exactly din0_WIDTH+1 cycles after the accepting edge (27 at defaults).
REQ-020 Quotient truncates toward zero; remainder takes the dividend's sign; |rem| < |din1|.
REQ-021 Magnitude of -2^(din0_WIDTH-1) SHALL be formed in din0_WIDTH+1 bits so it is exact.
REQ-022 -2^25 / -1 overflows; dout SHALL wrap to -2^25 (low dout_WIDTH bits), rem 0, dz 0.
REQ-023 din1=0: iterations still run (same latency); result dout = all ones, rem = 0, dz = 1.
REQ-024 start while busy is ignored; no queueing; operands change freely during CALC.
REQ-025 ce low in any state stalls counter, FSM and outputs; done pulse is extended only in that it lasts while ce low in FIN, then clears on first ce-high cycle.
REQ-026 start and done coincide never; a start in the cycle after done is accepted normally.

Reset
REQ-027 ap_rst_n low asynchronously forces IDLE, counter 0, busy 0, done 0, dout 0, rem 0, dz 0.
REQ-028 Reset mid-operation aborts the division; no done is produced for it.
REQ-029 Reset release is synchronized to ap_clk by the instantiating top; block takes first start on the first edge after release.

Structure
REQ-030 Package case_3_sdiv_pkg SHALL hold the state enum (IDLE, CALC, FIN), default widths, and counter width constant ($clog2(din0_WIDTH)).
REQ-031 One combinational sub-module case_3_sdiv_step SHALL implement a single restoring step (shift in bit, trial subtract, select, quotient bit); top holds FSM, counter, sign logic and registers.
REQ-032 No multipliers or vendor primitives; target 120-400 lines of RTL total.

Verification
REQ-033 din0=100, din1=7, start pulse, ce=1 -> done 27 cycles later, dout=14, rem=2, dz=0.
REQ-034 din0=-100, din1=7 -> dout=-14, rem=-2; din0=100, din1=-7 -> dout=-14, rem=2; din0=-100, din1=-7 -> dout=14, rem=-2.
REQ-035 din0=-33554432, din1=-1 -> dout=-33554432, rem=0, dz=0; din0=-33554432, din1=8191 -> dout=-4096, rem=-4096.
REQ-036 din0=12345, din1=0 -> dz=1, dout=all ones, rem=0, latency 27.
REQ-037 Start asserted again at cycle 5 of a division plus ce low for 3 cycles mid-CALC -> first result unaffected, done at cycle 30, second start ignored.
REQ-038 ap_rst_n pulsed low at cycle 10 of a division -> all outputs 0 immediately, no done; new start 1 cycle after release completes correctly.
